// File: rtl/btn_pkg.sv
// btn_pkg: shared definitions for the multi-channel button debouncer.
//   ch_state_e : per-channel FSM state encoding
//   cnt_w()    : bits needed to hold counts 0..v
//   max_u()    : larger of two unsigned values, for sizing shared counters
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        HELD,
        LONG,
        DB_RELEASE
    } ch_state_e;

    function automatic int cnt_w(input int unsigned v);
        return $clog2({32'd0, v} + 64'd1);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel: synchroniser, debounce FSM and hold counters for one button.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   btn_raw_i   : asynchronous raw pin
//   level_o     : debounced pressed level
//   press_o     : 1-cycle pulse on accepted press
//   release_o   : 1-cycle pulse on accepted release
//   click_o     : 1-cycle pulse on release of a press that never went long
//   long_o      : 1-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_o    : 1-cycle pulse every REPEAT_CYCLES after long_o while held
module btn_channel
    import btn_pkg::*;
#(
    parameter bit          ACTIVE_HIGH     = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 100000000,
    parameter int unsigned REPEAT_CYCLES   = 20000000,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic click_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int DB_W   = cnt_w(DEBOUNCE_CYCLES);
    localparam int HOLD_W = cnt_w(max_u(LONG_CYCLES, REPEAT_CYCLES));

    localparam logic [DB_W-1:0]   DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_ONE  = DB_W'(1);
    localparam logic [HOLD_W-1:0] LONG_TH = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_TH  = HOLD_W'(REPEAT_CYCLES - 1);

    logic [1:0]        sync_q;
    ch_state_e         state_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              long_seen_q;
    logic              s;
    logic              rep_hit;

    // Normalised "pressed" view of the synchronised pin.
    assign s       = sync_q[1] ^ ~ACTIVE_HIGH;
    assign rep_hit = hold_cnt_q == REP_TH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_seen_q <= 1'b0;
            level_o     <= 1'b0;
            press_o     <= 1'b0;
            release_o   <= 1'b0;
            click_o     <= 1'b0;
            long_o      <= 1'b0;
            repeat_o    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_raw_i};
            press_o   <= 1'b0;
            release_o <= 1'b0;
            click_o   <= 1'b0;
            long_o    <= 1'b0;
            repeat_o  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_q  <= DB_PRESS;
                        db_cnt_q <= DB_ONE;
                    end
                end
                DB_PRESS: begin
                    if (!s) begin
                        state_q  <= IDLE;
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DB_MAX) begin
                        state_q     <= HELD;
                        level_o     <= 1'b1;
                        press_o     <= 1'b1;
                        hold_cnt_q  <= '0;
                        long_seen_q <= 1'b0;
                        db_cnt_q    <= '0;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                // The long threshold outranks a release seen in the same cycle;
                // LONG then picks up the release one cycle later.
                HELD: begin
                    if (hold_cnt_q == LONG_TH) begin
                        state_q     <= LONG;
                        long_o      <= 1'b1;
                        long_seen_q <= 1'b1;
                        hold_cnt_q  <= '0;
                    end else if (!s) begin
                        state_q  <= DB_RELEASE;
                        db_cnt_q <= DB_ONE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                // Without auto-repeat the counter still wraps at the repeat
                // period so it can never overflow during an arbitrarily long hold.
                LONG: begin
                    if (REPEAT_EN && rep_hit) begin
                        repeat_o   <= 1'b1;
                        hold_cnt_q <= '0;
                    end else if (!s) begin
                        state_q  <= DB_RELEASE;
                        db_cnt_q <= DB_ONE;
                    end else begin
                        hold_cnt_q <= rep_hit ? '0 : hold_cnt_q + 1'b1;
                    end
                end
                // hold_cnt is frozen while the release is being qualified; a
                // rejected release resumes counting on the edge that returns.
                DB_RELEASE: begin
                    if (s) begin
                        state_q    <= long_seen_q ? LONG : HELD;
                        db_cnt_q   <= '0;
                        hold_cnt_q <= (long_seen_q && rep_hit) ? '0 : hold_cnt_q + 1'b1;
                    end else if (db_cnt_q == DB_MAX) begin
                        state_q   <= IDLE;
                        level_o   <= 1'b0;
                        release_o <= 1'b1;
                        click_o   <= ~long_seen_q;
                        db_cnt_q  <= '0;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/button_debounce_multi.sv
// button_debounce_multi: bank of N_CH independent debounced pushbuttons.
//   clk, rst_n    : system clock, asynchronous active-low reset
//   btn_raw       : asynchronous raw button pins
//   btn_level     : debounced pressed level per channel
//   press_pulse   : 1-cycle pulse on accepted press
//   release_pulse : 1-cycle pulse on accepted release
//   click_pulse   : 1-cycle pulse on release without a preceding long press
//   long_pulse    : 1-cycle pulse when a hold reaches LONG_CYCLES
//   repeat_pulse  : 1-cycle pulse every REPEAT_CYCLES after long_pulse
module button_debounce_multi
    import btn_pkg::*;
#(
    parameter int          N_CH            = 5,
    parameter bit          ACTIVE_HIGH     = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 100000000,
    parameter int unsigned REPEAT_CYCLES   = 20000000,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] click_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_channel #(
            .ACTIVE_HIGH    (ACTIVE_HIGH),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .REPEAT_EN      (REPEAT_EN)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_raw_i(btn_raw[i]),
            .level_o  (btn_level[i]),
            .press_o  (press_pulse[i]),
            .release_o(release_pulse[i]),
            .click_o  (click_pulse[i]),
            .long_o   (long_pulse[i]),
            .repeat_o (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_debounce_multi.sv
// tb_button_debounce_multi: directed scoreboard bench for button_debounce_multi.
module tb_button_debounce_multi;

    localparam int K_PRESS = 0, K_REL = 1, K_CLICK = 2, K_LONG = 3, K_REP = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] raw_a = 2'b00;
    logic [1:0] raw_b = 2'b11;
    logic [1:0] lvl_a, prs_a, rel_a, clc_a, lng_a, rep_a;
    logic [1:0] lvl_b, prs_b, rel_b, clc_b, lng_b, rep_b;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    button_debounce_multi #(
        .N_CH(2), .ACTIVE_HIGH(1'b1), .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(20), .REPEAT_CYCLES(6), .REPEAT_EN(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw_a), .btn_level(lvl_a),
        .press_pulse(prs_a), .release_pulse(rel_a), .click_pulse(clc_a),
        .long_pulse(lng_a), .repeat_pulse(rep_a)
    );

    button_debounce_multi #(
        .N_CH(2), .ACTIVE_HIGH(1'b0), .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(20), .REPEAT_CYCLES(6), .REPEAT_EN(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw_b), .btn_level(lvl_b),
        .press_pulse(prs_b), .release_pulse(rel_b), .click_pulse(clc_b),
        .long_pulse(lng_b), .repeat_pulse(rep_b)
    );

    typedef struct {
        int cyc;
        int inst;
        int ch;
        int kind;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  passes = 0;
    int  fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_ev(input int c, input int inst, input int ch, input int kind);
        exp_q.push_back('{c, inst, ch, kind});
    endtask

    function automatic logic [4:0] pulses(input int inst, input int ch);
        return (inst == 0) ? {rep_a[ch], lng_a[ch], clc_a[ch], rel_a[ch], prs_a[ch]}
                           : {rep_b[ch], lng_b[ch], clc_b[ch], rel_b[ch], prs_b[ch]};
    endfunction

    task automatic match(input int i, input int c, input int k);
        int idx = -1;
        foreach (exp_q[j])
            if (idx < 0 && exp_q[j].inst == i && exp_q[j].ch == c && exp_q[j].kind == k) idx = j;
        chk($sformatf("pulse_expected inst%0d ch%0d kind%0d at cyc %0d", i, c, k, cyc),
            32'(idx >= 0), 32'd1);
        if (idx >= 0) begin
            chk($sformatf("pulse_cycle inst%0d ch%0d kind%0d", i, c, k), cyc, exp_q[idx].cyc);
            exp_q.delete(idx);
        end
    endtask

    logic [4:0] mon_p;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 2; c++) begin
                mon_p = pulses(i, c);
                for (int k = 0; k < 5; k++)
                    if (mon_p[k] === 1'b1) match(i, c, k);
            end
    end

    initial begin
        int c;
        int d;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Reset: press both channels, then reset asynchronously mid-cycle.
        c = cyc;
        raw_a = 2'b11;
        expect_ev(c + 7, 0, 0, K_PRESS);
        expect_ev(c + 7, 0, 1, K_PRESS);
        repeat (10) @(negedge clk);
        chk("t1_level_held", 32'(lvl_a), 32'h3);
        #2 rst_n = 1'b0;
        #1 chk("t1_async_level", 32'({lvl_a, lvl_b}), 32'h0);
        chk("t1_async_pulses", 32'({prs_a, rel_a, clc_a, lng_a, rep_a}), 32'h0);
        raw_a = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("t1_level_after", 32'({lvl_a, lvl_b}), 32'h0);

        // Clean press/release on ch0.
        c = cyc;
        raw_a[0] = 1'b1;
        expect_ev(c + 7, 0, 0, K_PRESS);
        repeat (6) @(negedge clk);
        chk("t2_level_before", 32'(lvl_a[0]), 32'h0);
        @(negedge clk);
        chk("t2_level_rise", 32'(lvl_a[0]), 32'h1);
        repeat (3) @(negedge clk);
        d = cyc;
        raw_a[0] = 1'b0;
        expect_ev(d + 7, 0, 0, K_REL);
        expect_ev(d + 7, 0, 0, K_CLICK);
        repeat (6) @(negedge clk);
        chk("t2_level_hold", 32'(lvl_a[0]), 32'h1);
        @(negedge clk);
        chk("t2_level_fall", 32'(lvl_a[0]), 32'h0);
        repeat (5) @(negedge clk);

        // Bounce: two short high bursts are rejected.
        raw_a[0] = 1'b1;
        repeat (3) @(negedge clk);
        raw_a[0] = 1'b0;
        @(negedge clk);
        raw_a[0] = 1'b1;
        repeat (3) @(negedge clk);
        raw_a[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_level_mid", 32'(lvl_a[0]), 32'h0);
        repeat (12) @(negedge clk);
        chk("t3_level_end", 32'(lvl_a[0]), 32'h0);

        // Long hold with auto-repeat on ch1.
        c = cyc;
        raw_a[1] = 1'b1;
        expect_ev(c + 7, 0, 1, K_PRESS);
        expect_ev(c + 27, 0, 1, K_LONG);
        expect_ev(c + 33, 0, 1, K_REP);
        expect_ev(c + 39, 0, 1, K_REP);
        expect_ev(c + 47, 0, 1, K_REL);
        repeat (40) @(negedge clk);
        chk("t4_level_held", 32'(lvl_a[1]), 32'h1);
        raw_a[1] = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_level_end", 32'(lvl_a[1]), 32'h0);

        // Release glitch at hold_cnt=5 on ch0; later release collides with a repeat.
        c = cyc;
        raw_a[0] = 1'b1;
        expect_ev(c + 7, 0, 0, K_PRESS);
        expect_ev(c + 29, 0, 0, K_LONG);
        expect_ev(c + 35, 0, 0, K_REP);
        expect_ev(c + 40, 0, 0, K_REL);
        repeat (10) @(negedge clk);
        raw_a[0] = 1'b0;
        repeat (2) @(negedge clk);
        raw_a[0] = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_level_held", 32'(lvl_a[0]), 32'h1);
        raw_a[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_level_end", 32'(lvl_a[0]), 32'h0);

        // Long threshold and release seen in the same cycle on ch1: long wins.
        c = cyc;
        raw_a[1] = 1'b1;
        expect_ev(c + 7, 0, 1, K_PRESS);
        expect_ev(c + 27, 0, 1, K_LONG);
        expect_ev(c + 32, 0, 1, K_REL);
        repeat (24) @(negedge clk);
        raw_a[1] = 1'b0;
        repeat (12) @(negedge clk);
        chk("t7_level_end", 32'(lvl_a[1]), 32'h0);

        // Active-low bank, both channels together, repeat disabled.
        c = cyc;
        raw_b = 2'b00;
        expect_ev(c + 7, 1, 0, K_PRESS);
        expect_ev(c + 7, 1, 1, K_PRESS);
        expect_ev(c + 27, 1, 0, K_LONG);
        expect_ev(c + 27, 1, 1, K_LONG);
        expect_ev(c + 47, 1, 0, K_REL);
        expect_ev(c + 47, 1, 1, K_REL);
        repeat (7) @(negedge clk);
        chk("t6_level_rise", 32'(lvl_b), 32'h3);
        repeat (33) @(negedge clk);
        chk("t6_level_held", 32'(lvl_b), 32'h3);
        raw_b = 2'b11;
        repeat (10) @(negedge clk);
        chk("t6_level_end", 32'(lvl_b), 32'h0);
        chk("t6_other_bank_idle", 32'(lvl_a), 32'h0);

        repeat (5) @(negedge clk);
        foreach (exp_q[j])
            $display("unmatched expectation: inst%0d ch%0d kind%0d cyc %0d",
                     exp_q[j].inst, exp_q[j].ch, exp_q[j].kind, exp_q[j].cyc);
        chk("end_all_events_seen", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/button_debounce_multi.md
Name: button_debounce_multi

Overview:
- Parametrised, multi-channel successor to the single-button edge detector.
- Per channel: synchronises a raw pushbutton, debounces it symmetrically on press and release, and emits one-cycle event pulses for press, release, short click, long press and auto-repeat.
- Sits between the board button pins and the lab control FSMs; the whole button bank is one instance.

Parameters:
N_CH, 5, number of independent button channels
ACTIVE_HIGH, 1, 1: raw input high = pressed; 0: raw input is inverted after the synchroniser
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised cycles required to accept a level change (>=1)
LONG_CYCLES, 100000000, cycles of debounced hold, counted from the press pulse, before long_pulse (>=1)
REPEAT_CYCLES, 20000000, period of repeat_pulse after long_pulse (>=1)
REPEAT_EN, 1, 1 enables auto-repeat; 0 suppresses repeat_pulse

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
btn_raw  in  N_CH  asynchronous raw button inputs
btn_level  out  N_CH  debounced pressed level
press_pulse  out  N_CH  1-cycle pulse on accepted press
release_pulse  out  N_CH  1-cycle pulse on accepted release
click_pulse  out  N_CH  1-cycle pulse on release when no long press occurred
long_pulse  out  N_CH  1-cycle pulse when hold reaches LONG_CYCLES
repeat_pulse  out  N_CH  1-cycle pulse every REPEAT_CYCLES after long_pulse while held

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (clk, rst_n).
  - While rst_n=0: all outputs 0, synchronisers 0, counters 0, every channel in IDLE.
  - Reset mid-operation aborts silently; no pulse is emitted on reset entry or exit.
- Synchroniser: 2-flop chain per channel. s = sync[1] XOR ~ACTIVE_HIGH.
- Channel FSM states:
  - IDLE: level 0. s=1 -> DB_PRESS, db_cnt=1.
  - DB_PRESS:
    - s=0 -> IDLE, db_cnt=0 (bounce rejected, no pulse).
    - s=1 and db_cnt==DEBOUNCE_CYCLES -> HELD: level<=1, press_pulse=1, hold_cnt=0, long_seen=0.
    - Otherwise db_cnt++.
  - HELD: hold_cnt++ each cycle.
    - hold_cnt==LONG_CYCLES-1 -> LONG: long_pulse=1, long_seen=1, hold_cnt=0.
    - s=0 -> DB_RELEASE, db_cnt=1; hold_cnt frozen.
  - LONG: hold_cnt++.
    - REPEAT_EN and hold_cnt==REPEAT_CYCLES-1 -> repeat_pulse=1, hold_cnt=0.
    - s=0 -> DB_RELEASE.
  - DB_RELEASE:
    - s=1 -> return to HELD or LONG (selected by long_seen); hold_cnt resumes from its frozen value.
    - s=0 and db_cnt==DEBOUNCE_CYCLES -> IDLE: level<=0, release_pulse=1, and click_pulse=1 if long_seen=0.
    - Otherwise db_cnt++.
- Latency: a clean raw edge produces press_pulse/release_pulse and the btn_level change at clock edge DEBOUNCE_CYCLES+2 after the first edge that samples it.
- Registering: all outputs are registered; all pulses are exactly 1 cycle wide.
- Simultaneous events:
  - release_pulse and click_pulse coincide.
  - If the long threshold and s=0 occur in the same cycle, long wins: long_pulse=1 and the FSM goes to LONG, which handles the release next cycle.
  - Repeat threshold and s=0 in the same cycle: repeat wins the same way.
- Counter widths: db_cnt is $clog2(DEBOUNCE_CYCLES+1) bits; hold_cnt is $clog2(max(LONG_CYCLES,REPEAT_CYCLES)+1) bits. Neither counter can wrap, because each resets at its threshold.
- Channel independence: channels share no state; simultaneous activity on all N_CH channels is legal.

Decomposition:
- Shared package btn_pkg: channel state enum (IDLE, DB_PRESS, HELD, LONG, DB_RELEASE) and a width helper function.
- Sub-module btn_channel: synchroniser, FSM and counters for one channel.
- The top level instantiates btn_channel N_CH times via generate and concatenates the outputs.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=6, N_CH=2):
1. Reset: rst_n=0 asserted mid-cycle with btn_raw=2'b11 -> all outputs 0 immediately; after release of reset with btn_raw=0, no pulses are seen.
2. Clean press on ch0, held 10 cycles, then released:
   - press_pulse[0] and btn_level[0] rise at edge 6.
   - release_pulse[0] and click_pulse[0] occur 6 edges after the falling raw edge.
   - long_pulse[0] stays 0.
3. Bounce: ch0 toggled high 3 cycles, low 1, high 3, low -> no pulses; btn_level[0] stays 0.
4. Long hold on ch1 for 40 cycles:
   - long_pulse[1] at 20 cycles after press_pulse[1].
   - repeat_pulse[1] at +6 and +12.
   - On release: release_pulse[1]=1, click_pulse[1]=0.
5. Release glitch: ch0 held, 2-cycle low glitch at hold_cnt=5 -> no release_pulse; long_pulse[0] arrives 2 cycles late (hold_cnt frozen during the glitch).
6. ACTIVE_HIGH=0 with concurrent channels: both channels pressed (raw 0) on the same cycle -> both press_pulse bits assert on the same edge; REPEAT_EN=0 run -> no repeat_pulse after long_pulse.
